// File: rtl/fp_add_seq_ctrl_pkg.sv
// rtl/fp_add_seq_ctrl_pkg.sv - shared types, stage/flag indices and decode helpers for the FP add/sub sequencer
package fp_add_seq_ctrl_pkg;

    // Error code leaving the error_check stage.
    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_INVALID   = 2'd1,
        ERR_OVERFLOW  = 2'd2,
        ERR_UNDERFLOW = 2'd3
    } o_err_t;

    // Operand class reported by the unpack stage.
    typedef enum logic [1:0] {
        IN_NORMAL = 2'd0,
        IN_ZERO   = 2'd1,
        IN_INF    = 2'd2,
        IN_NAN    = 2'd3
    } i_err_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_UNPACK = 3'd1,
        S_ALIGN  = 3'd2,
        S_ADD    = 3'd3,
        S_NORM   = 3'd4,
        S_ROUND  = 3'd5,
        S_CHECK  = 3'd6,
        S_RESP   = 3'd7
    } seq_state_t;

    localparam int STG_W      = 5;
    localparam int STG_UNPACK = 0;
    localparam int STG_ALIGN  = 1;
    localparam int STG_ADD    = 2;
    localparam int STG_NORM   = 3;
    localparam int STG_ROUND  = 4;

    localparam int FLAG_INEXACT   = 0;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_DIVZERO   = 3;
    localparam int FLAG_INVALID   = 4;

    // Datapath stage enable that belongs to a sequencer state.
    function automatic logic [STG_W-1:0] stage_onehot(input seq_state_t s);
        logic [STG_W-1:0] v;
        v = '0;
        case (s)
            S_UNPACK: v[STG_UNPACK] = 1'b1;
            S_ALIGN:  v[STG_ALIGN]  = 1'b1;
            S_ADD:    v[STG_ADD]    = 1'b1;
            S_NORM:   v[STG_NORM]   = 1'b1;
            S_ROUND:  v[STG_ROUND]  = 1'b1;
            default:  v = '0;
        endcase
        return v;
    endfunction

    // Overflow and underflow always imply an inexact result.
    function automatic logic [4:0] err_to_flags(input o_err_t e);
        logic [4:0] v;
        v = '0;
        case (e)
            ERR_INVALID: v[FLAG_INVALID] = 1'b1;
            ERR_OVERFLOW: begin
                v[FLAG_OVERFLOW] = 1'b1;
                v[FLAG_INEXACT]  = 1'b1;
            end
            ERR_UNDERFLOW: begin
                v[FLAG_UNDERFLOW] = 1'b1;
                v[FLAG_INEXACT]   = 1'b1;
            end
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/fp_add_seq_ctrl_flag_acc.sv
// rtl/fp_add_seq_ctrl_flag_acc.sv - sticky exception flag accumulator with clear priority
// Ports: clk, rst (sync, active-high), upd (take dp error this edge), err (o_err_t),
//        clr (clear flags, wins over upd), flags [FLAG_W-1:0] sticky {NV,DZ,OF,UF,NX}.
module fp_flag_acc
    import fp_add_seq_ctrl_pkg::*;
#(
    parameter int FLAG_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              upd,
    input  o_err_t            err,
    input  logic              clr,
    output logic [FLAG_W-1:0] flags
);

    logic [FLAG_W-1:0] set_bits;

    assign set_bits = FLAG_W'(err_to_flags(err));

    always_ff @(posedge clk) begin
        if (rst) begin
            flags <= '0;
        end else if (clr) begin
            flags <= '0;
        end else if (upd) begin
            flags <= flags | set_bits;
        end
    end

endmodule

// File: rtl/fp_add_seq_ctrl.sv
// rtl/fp_add_seq_ctrl.sv - sequencing controller for the multi-cycle FP add/sub datapath
// Ports: clk, rst (sync, active-high); request in_valid/in_ready with op_a, op_b, op_sub;
//        datapath side dp_a, dp_b, dp_sub, stage_en (one-hot {ROUND,NORM,ADD,ALIGN,UNPACK}),
//        dp_special, dp_result, dp_err; response out_valid/out_ready with res, res_err;
//        sticky flags with flags_clr; flush aborts the in-flight operation.
module fp_add_seq_ctrl
    import fp_add_seq_ctrl_pkg::*;
#(
    parameter int NORM_CYCLES = 2,
    parameter int FLAG_W      = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       op_a,
    input  logic [31:0]       op_b,
    input  logic              op_sub,
    output logic [31:0]       dp_a,
    output logic [31:0]       dp_b,
    output logic              dp_sub,
    output logic [STG_W-1:0]  stage_en,
    input  logic              dp_special,
    input  logic [31:0]       dp_result,
    input  o_err_t            dp_err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       res,
    output o_err_t            res_err,
    output logic [FLAG_W-1:0] flags,
    input  logic              flags_clr,
    input  logic              flush
);

    localparam int              CNT_W     = 4;
    localparam logic [CNT_W-1:0] NORM_LAST = CNT_W'(NORM_CYCLES - 1);

    seq_state_t       state;
    seq_state_t       nxt;
    logic [CNT_W-1:0] norm_cnt;
    logic             norm_done;
    logic             accept;
    logic             check_upd;

    assign norm_done = (norm_cnt == NORM_LAST);
    assign accept    = (state == S_IDLE) && in_valid && !flush;
    assign check_upd = (state == S_CHECK) && !flush;

    // Flush dominates every transition, including an accept in IDLE.
    always_comb begin
        nxt = S_IDLE;
        if (!flush) begin
            case (state)
                S_IDLE:   nxt = in_valid ? S_UNPACK : S_IDLE;
                S_UNPACK: nxt = dp_special ? S_CHECK : S_ALIGN;
                S_ALIGN:  nxt = S_ADD;
                S_ADD:    nxt = S_NORM;
                S_NORM:   nxt = norm_done ? S_ROUND : S_NORM;
                S_ROUND:  nxt = S_CHECK;
                S_CHECK:  nxt = S_RESP;
                S_RESP:   nxt = out_ready ? S_IDLE : S_RESP;
                default:  nxt = S_IDLE;
            endcase
        end
    end

    // Handshake and stage outputs are registered from the next state so they
    // line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            stage_en  <= '0;
            dp_a      <= '0;
            dp_b      <= '0;
            dp_sub    <= 1'b0;
            res       <= '0;
            res_err   <= ERR_NONE;
            norm_cnt  <= '0;
        end else begin
            state     <= nxt;
            in_ready  <= (nxt == S_IDLE);
            out_valid <= (nxt == S_RESP);
            stage_en  <= stage_onehot(nxt);

            if (accept) begin
                dp_a   <= op_a;
                dp_b   <= op_b;
                dp_sub <= op_sub;
            end

            // Counter is zero outside NORM, so each NORM visit starts fresh.
            if ((state == S_NORM) && !flush && !norm_done) begin
                norm_cnt <= norm_cnt + 4'd1;
            end else begin
                norm_cnt <= '0;
            end

            if (check_upd) begin
                res     <= dp_result;
                res_err <= dp_err;
            end
        end
    end

    fp_flag_acc #(
        .FLAG_W (FLAG_W)
    ) u_flag_acc (
        .clk   (clk),
        .rst   (rst),
        .upd   (check_upd),
        .err   (dp_err),
        .clr   (flags_clr),
        .flags (flags)
    );

endmodule

// File: tb/tb_fp_add_seq_ctrl.sv
// tb/tb_fp_add_seq_ctrl.sv - scoreboard testbench for fp_add_seq_ctrl
module tb_fp_add_seq_ctrl;
    import fp_add_seq_ctrl_pkg::*;

    localparam int N = 2;

    typedef struct packed {
        logic [31:0] res;
        o_err_t      err;
        logic [4:0]  flags;
        logic [7:0]  lat;
        logic [7:0]  nst;
        logic [79:0] seq;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, in_valid, op_sub, dp_special, out_ready, flags_clr, flush;
    logic        in_ready, dp_sub, out_valid;
    logic [31:0] op_a, op_b, dp_a, dp_b, dp_result, res;
    logic [4:0]  stage_en, flags;
    o_err_t      dp_err, res_err;

    fp_add_seq_ctrl #(.NORM_CYCLES(N), .FLAG_W(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .op_sub(op_sub),
        .dp_a(dp_a), .dp_b(dp_b), .dp_sub(dp_sub), .stage_en(stage_en),
        .dp_special(dp_special), .dp_result(dp_result), .dp_err(dp_err),
        .out_valid(out_valid), .out_ready(out_ready), .res(res), .res_err(res_err),
        .flags(flags), .flags_clr(flags_clr), .flush(flush)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    exp_t sb[$];
    logic [4:0]  model_flags = '0;
    logic [31:0] last_res = '0;
    o_err_t      last_err = ERR_NONE;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic fail_now(input string nm);
        n_chk++;
        $display("FAIL %s: condition not reached (cycle %0d)", nm, cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Flag bits an error code contributes: NV=16, OF=4, UF=2, NX=1.
    function automatic logic [4:0] exp_flag_bits(input o_err_t e);
        case (e)
            ERR_INVALID:   return 5'd16;
            ERR_OVERFLOW:  return 5'd4 + 5'd1;
            ERR_UNDERFLOW: return 5'd2 + 5'd1;
            default:       return 5'd0;
        endcase
    endfunction

    // Monitor: reconstructs latency and stage trace, compares responses against the scoreboard head.
    bit          inflight = 0, got_v = 0, chk_ir = 0;
    int          start = 0, tn = 0;
    logic [79:0] tr = '0;
    exp_t        cur;

    always @(negedge clk) begin
        if (rst) begin
            inflight = 0;
            chk_ir   = 0;
        end else begin
            if (chk_ir) begin
                chk("in_ready_after_resp", in_ready, 1);
                chk_ir = 0;
            end
            if (inflight && stage_en != 0) begin
                if (tn < 16) tr[tn*5 +: 5] = stage_en;
                tn++;
            end
            if (out_valid) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_out_valid: got out_valid=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    cur = sb[0];
                    if (inflight && !got_v) begin
                        got_v = 1;
                        chk("latency", cyc - start - 1, cur.lat);
                        chk("stage_count", tn, cur.nst);
                        chk("stage_seq", tr, cur.seq);
                    end
                    chk("res", res, cur.res);
                    chk("res_err", res_err, cur.err);
                    chk("flags", flags, cur.flags);
                    chk("in_ready_busy", in_ready, 0);
                    if (out_ready) begin
                        void'(sb.pop_front());
                        inflight = 0;
                        chk_ir   = 1;
                    end
                end
            end
            if (flush) inflight = 0;
            if (in_valid && in_ready && !flush) begin
                inflight = 1;
                start    = cyc;
                got_v    = 0;
                tr       = '0;
                tn       = 0;
            end
        end
    end

    task automatic wait_in_ready();
        int k = 0;
        while (!in_ready && k < 60) begin
            step();
            k++;
        end
        if (!in_ready) fail_now("wait_in_ready");
    endtask

    task automatic accept(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r,
                          input logic sub, input logic spec, input o_err_t err);
        wait_in_ready();
        op_a = a; op_b = b; op_sub = sub;
        dp_special = spec; dp_result = r; dp_err = err;
        in_valid = 1;
        step();
        in_valid = 0;
        chk("dp_a", dp_a, a);
        chk("dp_b", dp_b, b);
        chk("dp_sub", dp_sub, sub);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r,
                          input logic spec, input o_err_t err, input int hold, input bit clr);
        exp_t e;
        int   lat;
        int   k;
        lat = spec ? 2 : 4 + N + 1;
        model_flags = clr ? 5'd0 : (model_flags | exp_flag_bits(err));
        e.res = r; e.err = err; e.flags = model_flags; e.lat = 8'(lat);
        e.seq = '0;
        e.seq[4:0] = 5'd1 << STG_UNPACK;
        if (spec) begin
            e.nst = 8'd1;
        end else begin
            e.seq[9:5]   = 5'd1 << STG_ALIGN;
            e.seq[14:10] = 5'd1 << STG_ADD;
            for (int i = 0; i < N; i++) e.seq[(3+i)*5 +: 5] = 5'd1 << STG_NORM;
            e.seq[(3+N)*5 +: 5] = 5'd1 << STG_ROUND;
            e.nst = 8'(4 + N);
        end
        sb.push_back(e);
        accept(a, b, r, 1'($urandom), spec, err);
        if (clr) begin
            repeat (lat - 1) step();
            flags_clr = 1;
            step();
            flags_clr = 0;
        end
        k = 0;
        while (!out_valid && k < 40) begin
            step();
            k++;
        end
        if (!out_valid) begin
            fail_now("wait_out_valid");
            sb.delete();
        end
        out_ready = 0;
        repeat (hold) step();
        out_ready = 1;
        step();
        out_ready = 0;
        last_res = r;
        last_err = err;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; in_valid = 0; op_a = 0; op_b = 0; op_sub = 0; dp_special = 0;
        dp_result = 0; dp_err = ERR_NONE; out_ready = 0; flags_clr = 0; flush = 0;
        step(); step();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_stage_en", stage_en, 0);
        chk("rst_res", res, 0);
        chk("rst_res_err", res_err, ERR_NONE);
        chk("rst_flags", flags, 0);
        chk("rst_dp_a", dp_a, 0);
        rst = 0;
        step();

        // Normal add, then bypass, then backpressure.
        run_op(32'h3F800000, 32'h40000000, 32'h40400000, 0, ERR_NONE, 0, 0);
        chk("flags_after_normal", flags, 5'b00000);
        run_op($urandom, $urandom, 32'h7FFFFFFF, 1, ERR_INVALID, 0, 0);
        chk("flags_after_bypass", flags, 5'b10000);
        run_op($urandom, $urandom, $urandom, 0, ERR_NONE, 4, 0);

        // Flush while in NORM: back to IDLE, no response, res and flags kept.
        accept($urandom, $urandom, $urandom, 0, 0, ERR_OVERFLOW);
        repeat (3) step();
        chk("norm_stage_before_flush", stage_en, 5'b01000);
        flush = 1;
        step();
        flush = 0;
        chk("flush_in_ready", in_ready, 1);
        chk("flush_stage_en", stage_en, 0);
        chk("flush_out_valid", out_valid, 0);
        chk("flush_res", res, last_res);
        chk("flush_res_err", res_err, last_err);
        chk("flush_flags", flags, model_flags);
        repeat (10) step();

        // Flush in IDLE beats a request.
        in_valid = 1; flush = 1;
        step();
        in_valid = 0; flush = 0;
        chk("idle_flush_in_ready", in_ready, 1);
        chk("idle_flush_stage_en", stage_en, 0);
        step();

        // Clear coinciding with CHECK wins; next overflow sets OF and NX.
        run_op($urandom, $urandom, $urandom, 0, ERR_OVERFLOW, 0, 1);
        chk("flags_clr_at_check", flags, 5'b00000);
        run_op($urandom, $urandom, $urandom, 0, ERR_OVERFLOW, 1, 0);
        chk("flags_overflow", flags, 5'b00101);

        for (int i = 0; i < 30; i++) begin
            run_op($urandom, $urandom, $urandom, $urandom_range(0, 3) == 0,
                   o_err_t'($urandom_range(0, 3)), $urandom_range(0, 4),
                   $urandom_range(0, 5) == 0);
        end

        // Clear while idle.
        flags_clr = 1;
        step();
        flags_clr = 0;
        model_flags = '0;
        chk("idle_flags_clr", flags, 0);

        // Reset in ALIGN with flush asserted and NV set.
        run_op($urandom, $urandom, $urandom, 1, ERR_INVALID, 0, 0);
        chk("flags_before_reset", flags, 5'b10000);
        accept(32'h12345678, 32'h9ABCDEF0, $urandom, 1, 0, ERR_NONE);
        step();
        chk("align_stage", stage_en, 5'b00010);
        rst = 1; flush = 1;
        step();
        rst = 0; flush = 0;
        model_flags = '0;
        chk("rst2_in_ready", in_ready, 1);
        chk("rst2_out_valid", out_valid, 0);
        chk("rst2_stage_en", stage_en, 0);
        chk("rst2_dp_a", dp_a, 0);
        chk("rst2_dp_b", dp_b, 0);
        chk("rst2_dp_sub", dp_sub, 0);
        chk("rst2_res", res, 0);
        chk("rst2_res_err", res_err, ERR_NONE);
        chk("rst2_flags", flags, 0);

        run_op($urandom, $urandom, $urandom, 0, ERR_UNDERFLOW, 2, 0);
        repeat (5) step();
        chk("scoreboard_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
